// File: rtl/mantissa_align_pipe_pkg.sv
// Shared types and constants for the FP add/sub operand alignment path.
// Holds default widths, the GRS extension width and operand/result bundles.
package fp_calc_pkg;

  localparam int MAN_W_DEF = 10;
  localparam int EXP_W_DEF = 5;
  localparam int GRS_W     = 3;

  typedef struct packed {
    logic [EXP_W_DEF-1:0] exp;
    logic [MAN_W_DEF-1:0] man;
  } fp_operand_t;

  typedef struct packed {
    logic [EXP_W_DEF-1:0]         exp;
    logic [MAN_W_DEF+GRS_W-1:0]   man_big;
    logic [MAN_W_DEF+GRS_W-1:0]   man_sml;
    logic                         swap;
  } aligned_t;

endpackage

// File: rtl/mantissa_align_pipe_if.sv
// Valid/ready bundle between operand unpack, the aligner and the adder.
// master drives operands and out_ready; slave (the aligner) drives the rest.
interface mantissa_align_pipe_if
  import fp_calc_pkg::*;
#(
  parameter int MAN_W = MAN_W_DEF,
  parameter int EXP_W = EXP_W_DEF
);

  logic                     in_valid;
  logic                     in_ready;
  logic [EXP_W-1:0]         in_exp_a;
  logic [MAN_W-1:0]         in_man_a;
  logic [EXP_W-1:0]         in_exp_b;
  logic [MAN_W-1:0]         in_man_b;
  logic                     out_valid;
  logic                     out_ready;
  logic [EXP_W-1:0]         out_exp;
  logic [MAN_W+GRS_W-1:0]   out_man_big;
  logic [MAN_W+GRS_W-1:0]   out_man_sml;
  logic                     out_swap;

  modport master (
    output in_valid, in_exp_a, in_man_a,
    output in_exp_b, in_man_b, out_ready,
    input  in_ready, out_valid, out_exp,
    input  out_man_big, out_man_sml, out_swap
  );

  modport slave (
    input  in_valid, in_exp_a, in_man_a,
    input  in_exp_b, in_man_b, out_ready,
    output in_ready, out_valid, out_exp,
    output out_man_big, out_man_sml, out_swap
  );

endinterface

// File: rtl/mantissa_align_pipe_rshift.sv
// Combinational right shifter for the small mantissa, W bits by shamt.
// With MANTISSA_ALIGN_STICKY_EN defined, shifted-out bits OR into bit 0.
module mantissa_rshift #(
  parameter int W    = 13,
  parameter int SH_W = 5
) (
  input  logic [W-1:0]    din,
  input  logic [SH_W-1:0] shamt,
  output logic [W-1:0]    dout
);

  logic [W-1:0] shifted;

  // Shift amounts >= W naturally produce zero.
  assign shifted = din >> shamt;

`ifdef MANTISSA_ALIGN_STICKY_EN
  logic lost;

  always_comb begin
    lost = 1'b0;
    for (int i = 0; i < W; i++) begin
      if (i < int'(shamt)) lost = lost | din[i];
    end
  end

  assign dout = {shifted[W-1:1], shifted[0] | lost};
`else
  assign dout = shifted;
`endif

endmodule

// File: rtl/mantissa_align_pipe.sv
// Two-stage operand aligner: stage 1 compare/swap, stage 2 shift + GRS.
// Ports: clk, reset (sync, high), io (slave modport). Option: MANTISSA_ALIGN_STICKY_EN.
module mantissa_align_pipe
  import fp_calc_pkg::*;
#(
  parameter int MAN_W = MAN_W_DEF,
  parameter int EXP_W = EXP_W_DEF
) (
  input logic clk,
  input logic reset,
  mantissa_align_pipe_if.slave io
);

  localparam int EW = MAN_W + GRS_W;

  logic             s1_valid;
  logic [EXP_W-1:0] s1_exp;
  logic [MAN_W-1:0] s1_man_big;
  logic [MAN_W-1:0] s1_man_sml;
  logic [EXP_W-1:0] s1_diff;
  logic             s1_swap;

  logic             s1_load;
  logic             s2_load;
  logic             swap;
  logic [EW-1:0]    sml_ext;

  assign s2_load     = ~io.out_valid | io.out_ready;
  assign s1_load     = ~s1_valid | s2_load;
  assign io.in_ready = s1_load;

  // Full tie keeps A in the big lane.
  assign swap = (io.in_exp_b > io.in_exp_a) |
                ((io.in_exp_b == io.in_exp_a) &
                 (io.in_man_b > io.in_man_a));

  mantissa_rshift #(
    .W    (EW),
    .SH_W (EXP_W)
  ) u_rshift (
    .din   ({s1_man_sml, {GRS_W{1'b0}}}),
    .shamt (s1_diff),
    .dout  (sml_ext)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid       <= 1'b0;
      s1_exp         <= '0;
      s1_man_big     <= '0;
      s1_man_sml     <= '0;
      s1_diff        <= '0;
      s1_swap        <= 1'b0;
      io.out_valid   <= 1'b0;
      io.out_exp     <= '0;
      io.out_man_big <= '0;
      io.out_man_sml <= '0;
      io.out_swap    <= 1'b0;
    end else begin
      if (s1_load) begin
        s1_valid <= io.in_valid;
        if (io.in_valid) begin
          s1_swap <= swap;
          if (swap) begin
            s1_exp     <= io.in_exp_b;
            s1_man_big <= io.in_man_b;
            s1_man_sml <= io.in_man_a;
            s1_diff    <= io.in_exp_b - io.in_exp_a;
          end else begin
            s1_exp     <= io.in_exp_a;
            s1_man_big <= io.in_man_a;
            s1_man_sml <= io.in_man_b;
            s1_diff    <= io.in_exp_a - io.in_exp_b;
          end
        end
      end
      if (s2_load) begin
        io.out_valid <= s1_valid;
        if (s1_valid) begin
          io.out_exp     <= s1_exp;
          io.out_man_big <= {s1_man_big, {GRS_W{1'b0}}};
          io.out_man_sml <= sml_ext;
          io.out_swap    <= s1_swap;
        end
      end
    end
  end

endmodule

// File: tb/tb_mantissa_align_pipe.sv
// Directed bench for mantissa_align_pipe: vector table plus stall/reset runs.
// Expected sticky bits follow MANTISSA_ALIGN_STICKY_EN when defined.
module tb_mantissa_align_pipe;
  import fp_calc_pkg::*;

`ifdef MANTISSA_ALIGN_STICKY_EN
  localparam bit STICKY = 1'b1;
`else
  localparam bit STICKY = 1'b0;
`endif

  typedef struct packed {
    logic [4:0]  exp_a;
    logic [9:0]  man_a;
    logic [4:0]  exp_b;
    logic [9:0]  man_b;
    logic [4:0]  exp;
    logic [12:0] big;
    logic [12:0] sml_tr;
    logic [12:0] sml_st;
    logic        swap;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  mantissa_align_pipe_if #(.MAN_W(10), .EXP_W(5)) bus ();

  mantissa_align_pipe #(.MAN_W(10), .EXP_W(5)) dut (
    .clk   (clk),
    .reset (reset),
    .io    (bus)
  );

  vec_t vt[11];

  task automatic check(input string nm, input logic [63:0] got,
                       input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", nm, got, want);
    end
  endtask

  function automatic aligned_t want_of(input vec_t v);
    aligned_t r;
    r.exp     = v.exp;
    r.man_big = v.big;
    r.man_sml = STICKY ? v.sml_st : v.sml_tr;
    r.swap    = v.swap;
    return r;
  endfunction

  function automatic aligned_t got_now();
    aligned_t r;
    r.exp     = bus.out_exp;
    r.man_big = bus.out_man_big;
    r.man_sml = bus.out_man_sml;
    r.swap    = bus.out_swap;
    return r;
  endfunction

  task automatic drive(input vec_t v);
    bus.in_exp_a = v.exp_a;
    bus.in_man_a = v.man_a;
    bus.in_exp_b = v.exp_b;
    bus.in_man_b = v.man_b;
    bus.in_valid = 1'b1;
  endtask

  initial begin
    aligned_t held;
    int lat;
    int n;
    bit acc;
    bit stable;
    bit seen;

    vt[0]  = '{5'd15, 10'h200, 5'd13, 10'h300,
               5'd15, 13'h1000, 13'h0600, 13'h0600, 1'b0};
    vt[1]  = '{5'd10, 10'h3FF, 5'd12, 10'h200,
               5'd12, 13'h1000, 13'h07FE, 13'h07FE, 1'b1};
    vt[2]  = '{5'd20, 10'h200, 5'd2, 10'h3FF,
               5'd20, 13'h1000, 13'h0000, 13'h0001, 1'b0};
    vt[3]  = '{5'd7, 10'h250, 5'd7, 10'h250,
               5'd7, 13'h1280, 13'h1280, 13'h1280, 1'b0};
    vt[4]  = '{5'd9, 10'h200, 5'd9, 10'h201,
               5'd9, 13'h1008, 13'h1000, 13'h1000, 1'b1};
    vt[5]  = '{5'd20, 10'h3FF, 5'd8, 10'h3FF,
               5'd20, 13'h1FF8, 13'h0001, 13'h0001, 1'b0};
    vt[6]  = '{5'd13, 10'h200, 5'd0, 10'h200,
               5'd13, 13'h1000, 13'h0000, 13'h0001, 1'b0};
    vt[7]  = '{5'd5, 10'h200, 5'd1, 10'h201,
               5'd5, 13'h1000, 13'h0100, 13'h0101, 1'b0};
    vt[8]  = '{5'd31, 10'h3FF, 5'd0, 10'h001,
               5'd31, 13'h1FF8, 13'h0000, 13'h0001, 1'b0};
    vt[9]  = '{5'd0, 10'h100, 5'd0, 10'h0FF,
               5'd0, 13'h0800, 13'h07F8, 13'h07F8, 1'b0};
    vt[10] = '{5'd3, 10'h155, 5'd6, 10'h2AA,
               5'd6, 13'h1550, 13'h0155, 13'h0155, 1'b1};

    bus.in_valid  = 1'b0;
    bus.in_exp_a  = '0;
    bus.in_man_a  = '0;
    bus.in_exp_b  = '0;
    bus.in_man_b  = '0;
    bus.out_ready = 1'b1;

    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_in_ready", 64'(bus.in_ready), 64'd1);
    check("rst_outputs", 64'(got_now()), 64'd0);

    // Single pairs: latency and aligned values.
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      drive(vt[i]);
      #1;
      check($sformatf("in_ready_%0d", i), 64'(bus.in_ready), 64'd1);
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      lat = 99;
      for (int k = 1; k <= 10; k++) begin
        @(negedge clk);
        if (bus.out_valid) begin
          lat = k;
          break;
        end
      end
      check($sformatf("latency_%0d", i), 64'(lat), 64'd2);
      check($sformatf("vec_%0d", i), 64'(got_now()),
            64'(want_of(vt[i])));
    end

    // Stall: out_ready low, three back-to-back pairs.
    @(negedge clk);
    bus.out_ready = 1'b0;
    drive(vt[0]);
    #1;
    check("stall_acc1", 64'(bus.in_ready), 64'd1);
    @(posedge clk);
    #1;
    drive(vt[1]);
    @(negedge clk);
    check("stall_acc2", 64'(bus.in_ready), 64'd1);
    @(posedge clk);
    #1;
    drive(vt[7]);
    @(negedge clk);
    check("stall_full", 64'(bus.in_ready), 64'd0);
    check("stall_ov", 64'(bus.out_valid), 64'd1);
    held = got_now();
    check("stall_head", 64'(held), 64'(want_of(vt[0])));
    stable = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (bus.in_ready || !bus.out_valid || got_now() !== held)
        stable = 1'b0;
    end
    check("stall_stable", 64'(stable), 64'd1);

    bus.out_ready = 1'b1;
    #1;
    n = 0;
    for (int c = 0; c < 20 && n < 3; c++) begin
      if (bus.out_valid) begin
        case (n)
          0: check("drain_0", 64'(got_now()), 64'(want_of(vt[0])));
          1: check("drain_1", 64'(got_now()), 64'(want_of(vt[1])));
          default:
            check("drain_2", 64'(got_now()), 64'(want_of(vt[7])));
        endcase
        n++;
      end
      acc = bus.in_valid && bus.in_ready;
      @(posedge clk);
      #1;
      if (acc) bus.in_valid = 1'b0;
      @(negedge clk);
    end
    check("drain_count", 64'(n), 64'd3);
    check("drain_in_valid", 64'(bus.in_valid), 64'd0);

    // Reset with both stages holding pairs.
    @(negedge clk);
    bus.out_ready = 1'b0;
    drive(vt[2]);
    @(posedge clk);
    #1;
    drive(vt[3]);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("pre_rst_full", 64'(bus.in_ready), 64'd0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("mid_rst_ov", 64'(bus.out_valid), 64'd0);
    check("mid_rst_ready", 64'(bus.in_ready), 64'd1);
    check("mid_rst_outs", 64'(got_now()), 64'd0);
    bus.out_ready = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (bus.out_valid) seen = 1'b1;
    end
    check("mid_rst_dropped", 64'(seen), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
